// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer: accepts one instruction, decodes it into register-file and
// ALU controls, holds them through execute, pulses the write enable in write-back.
module instr_sequencer #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            INSTR,
  input  logic                   INSTR_VALID,
  output logic                   INSTR_READY,
  output logic [2:0]             OUT1ADDRESS,
  output logic [2:0]             OUT2ADDRESS,
  output logic [2:0]             INADDRESS,
  output logic                   WRITE,
  output logic [2:0]             ALUOP,
  output logic [7:0]             IMMEDIATE,
  output logic                   IMM_SEL,
  output logic                   NEG_SEL,
  output logic [COUNT_WIDTH-1:0] INSTR_COUNT,
  output logic                   ERROR
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] aluop;
    logic       imm_sel;
    logic       neg_sel;
  } dec_t;

  function automatic dec_t decode_op(input logic [7:0] op);
    dec_t d;
    d = '0;
    unique case (op)
      8'h00:   begin d.legal = 1'b1; d.imm_sel = 1'b1; end
      8'h01:   d.legal = 1'b1;
      8'h02:   begin d.legal = 1'b1; d.aluop = 3'b001; end
      8'h03:   begin d.legal = 1'b1; d.aluop = 3'b001; d.neg_sel = 1'b1; end
      8'h04:   begin d.legal = 1'b1; d.aluop = 3'b010; end
      8'h05:   begin d.legal = 1'b1; d.aluop = 3'b011; end
      default: d = '0;
    endcase
    return d;
  endfunction

  state_e                 state_q, state_d;
  logic [31:0]            ir_q, ir_d;
  logic                   ready_q, ready_d;
  logic [2:0]             out1_q, out1_d, out2_q, out2_d, inaddr_q, inaddr_d;
  logic                   write_q, write_d;
  logic [2:0]             aluop_q, aluop_d;
  logic [7:0]             imm_q, imm_d;
  logic                   imm_sel_q, imm_sel_d, neg_sel_q, neg_sel_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   error_q, error_d;
  dec_t                   dec_in, dec_ir;

  assign dec_in = decode_op(INSTR[31:24]);
  assign dec_ir = decode_op(ir_q[31:24]);

  // Decode outputs are loaded on the accept edge so they are already valid during DECODE.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ready_d   = ready_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    inaddr_d  = inaddr_q;
    write_d   = write_q;
    aluop_d   = aluop_q;
    imm_d     = imm_q;
    imm_sel_d = imm_sel_q;
    neg_sel_d = neg_sel_q;
    count_d   = count_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle: begin
        if (INSTR_VALID) begin
          state_d   = StDecode;
          ready_d   = 1'b0;
          ir_d      = INSTR;
          out1_d    = INSTR[10:8];
          out2_d    = INSTR[2:0];
          imm_d     = INSTR[7:0];
          aluop_d   = dec_in.aluop;
          imm_sel_d = dec_in.imm_sel;
          neg_sel_d = dec_in.neg_sel;
        end
      end
      StDecode: begin
        if (dec_ir.legal) begin
          state_d = StExec;
        end else begin
          state_d = StIdle;
          ready_d = 1'b1;
          error_d = 1'b1;
        end
      end
      StExec: begin
        state_d  = StWb;
        write_d  = 1'b1;
        inaddr_d = ir_q[18:16];
      end
      StWb: begin
        state_d = StIdle;
        ready_d = 1'b1;
        write_d = 1'b0;
        count_d = count_q + COUNT_WIDTH'(1);
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      ready_q   <= 1'b1;
      out1_q    <= '0;
      out2_q    <= '0;
      inaddr_q  <= '0;
      write_q   <= 1'b0;
      aluop_q   <= '0;
      imm_q     <= '0;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      count_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ready_q   <= ready_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      inaddr_q  <= inaddr_d;
      write_q   <= write_d;
      aluop_q   <= aluop_d;
      imm_q     <= imm_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      count_q   <= count_d;
      error_q   <= error_d;
    end
  end

  assign INSTR_READY = ready_q;
  assign OUT1ADDRESS = out1_q;
  assign OUT2ADDRESS = out2_q;
  assign INADDRESS   = inaddr_q;
  assign WRITE       = write_q;
  assign ALUOP       = aluop_q;
  assign IMMEDIATE   = imm_q;
  assign IMM_SEL     = imm_sel_q;
  assign NEG_SEL     = neg_sel_q;
  assign INSTR_COUNT = count_q;
  assign ERROR       = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table of single instructions plus hand-written
// sequences for reset, back-to-back valid and narrow-counter wrap.
module tb_instr_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTR = '0;
  logic        INSTR_VALID = 1'b0;

  logic        ready, write, imm_sel, neg_sel, error;
  logic [2:0]  out1, out2, inaddr, aluop;
  logic [7:0]  imm;
  logic [15:0] count;

  logic        n_ready, n_write, n_imm_sel, n_neg_sel, n_error;
  logic [2:0]  n_out1, n_out2, n_inaddr, n_aluop;
  logic [7:0]  n_imm;
  logic [1:0]  n_count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  logic exp_err = 1'b0;

  always #5 CLK = ~CLK;

  instr_sequencer #(.COUNT_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(ready), .OUT1ADDRESS(out1), .OUT2ADDRESS(out2), .INADDRESS(inaddr),
    .WRITE(write), .ALUOP(aluop), .IMMEDIATE(imm), .IMM_SEL(imm_sel), .NEG_SEL(neg_sel),
    .INSTR_COUNT(count), .ERROR(error)
  );

  instr_sequencer #(.COUNT_WIDTH(2)) dut_n (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(n_ready), .OUT1ADDRESS(n_out1), .OUT2ADDRESS(n_out2), .INADDRESS(n_inaddr),
    .WRITE(n_write), .ALUOP(n_aluop), .IMMEDIATE(n_imm), .IMM_SEL(n_imm_sel),
    .NEG_SEL(n_neg_sel), .INSTR_COUNT(n_count), .ERROR(n_error)
  );

  typedef struct {
    logic [31:0] instr;
    logic        legal;
    logic [2:0]  out1;
    logic [2:0]  out2;
    logic [7:0]  imm;
    logic [2:0]  aluop;
    logic        imm_sel;
    logic        neg_sel;
    logic [2:0]  inaddr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
  endtask

  // Runs one instruction from IDLE and checks every cycle until it is back in IDLE.
  task automatic run_vec(input vec_t v);
    @(negedge CLK);
    INSTR = v.instr;
    INSTR_VALID = 1'b1;
    @(negedge CLK);  // DECODE
    INSTR_VALID = 1'b0;
    INSTR = 32'hFFFF_FFFF;
    check("dec_ready", ready, 0);
    check("dec_write", write, 0);
    if (v.legal) begin
      check("dec_out1", out1, v.out1);
      check("dec_out2", out2, v.out2);
      check("dec_imm", imm, v.imm);
      check("dec_aluop", aluop, v.aluop);
      check("dec_imm_sel", imm_sel, v.imm_sel);
      check("dec_neg_sel", neg_sel, v.neg_sel);
      @(negedge CLK);  // EXEC
      check("exe_ready", ready, 0);
      check("exe_write", write, 0);
      check("exe_hold", {out1, out2, imm, aluop, imm_sel, neg_sel},
            {v.out1, v.out2, v.imm, v.aluop, v.imm_sel, v.neg_sel});
      @(negedge CLK);  // WB
      check("wb_ready", ready, 0);
      check("wb_write", write, 1);
      check("wb_inaddr", inaddr, v.inaddr);
      check("wb_hold", {out1, out2, imm, aluop, imm_sel, neg_sel},
            {v.out1, v.out2, v.imm, v.aluop, v.imm_sel, v.neg_sel});
      exp_count++;
    end
    @(negedge CLK);  // back in IDLE
    if (!v.legal) exp_err = 1'b1;
    check("idle_ready", ready, 1);
    check("idle_write", write, 0);
    check("idle_error", error, exp_err);
    check("idle_count", count, exp_count & 32'hFFFF);
    check("idle_count_n", n_count, exp_count & 32'h3);
  endtask

  initial begin
    int wb_seen;
    logic [2:0] wb_addr[3];
    logic [1:0] exp_n[5];

    vecs[0] = '{32'h0004_00F5, 1'b1, 3'd0, 3'd5, 8'hF5, 3'b000, 1'b1, 1'b0, 3'd4};
    vecs[1] = '{32'h0302_0105, 1'b1, 3'd1, 3'd5, 8'h05, 3'b001, 1'b0, 1'b1, 3'd2};
    vecs[2] = '{32'h0701_0203, 1'b0, 3'd0, 3'd0, 8'h00, 3'b000, 1'b0, 1'b0, 3'd0};
    vecs[3] = '{32'h0203_0102, 1'b1, 3'd1, 3'd2, 8'h02, 3'b001, 1'b0, 1'b0, 3'd3};
    vecs[4] = '{32'h0105_0307, 1'b1, 3'd3, 3'd7, 8'h07, 3'b000, 1'b0, 1'b0, 3'd5};
    vecs[5] = '{32'h0406_0411, 1'b1, 3'd4, 3'd1, 8'h11, 3'b010, 1'b0, 1'b0, 3'd6};
    vecs[6] = '{32'h0507_0516, 1'b1, 3'd5, 3'd6, 8'h16, 3'b011, 1'b0, 1'b0, 3'd7};

    do_reset();
    @(negedge CLK);
    check("rst_ready", ready, 1);
    check("rst_outs", {out1, out2, inaddr, write, aluop, imm, imm_sel, neg_sel}, 0);
    check("rst_count", count, 0);
    check("rst_error", error, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during EXEC of an add abandons it.
    @(negedge CLK);
    INSTR = 32'h0203_0102;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    check("rexe_ready", ready, 1);
    check("rexe_write", write, 0);
    check("rexe_count", count, 0);
    check("rexe_error", error, 0);
    repeat (3) begin
      @(negedge CLK);
      check("rexe_nowrite", write, 0);
    end

    // Reset beats a valid instruction on the same edge.
    @(negedge CLK);
    RESET = 1'b1;
    INSTR = 32'h0206_0705;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    check("rprio_ready", ready, 1);
    check("rprio_out1", out1, 0);

    // Valid held for 12 cycles with INSTR changing each cycle: accepts at cycles 0, 4, 8.
    wb_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      INSTR = 32'h0200_0000 | (32'((i + 1) % 8) << 16);
      INSTR_VALID = 1'b1;
      @(posedge CLK);
      #1;
      if (write) begin
        if (wb_seen < 3) wb_addr[wb_seen] = inaddr;
        wb_seen++;
      end
    end
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    exp_count += 3;
    check("b2b_writes", wb_seen, 3);
    if (wb_seen >= 3) begin
      check("b2b_addr0", wb_addr[0], 1);
      check("b2b_addr1", wb_addr[1], 5);
      check("b2b_addr2", wb_addr[2], 1);
    end
    check("b2b_count", count, exp_count);
    check("b2b_ready", ready, 1);

    // Narrow counter wraps 3 -> 0.
    do_reset();
    exp_n = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[3 + (i % 4)]);
      check("wrap_n", n_count, exp_n[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
